// File: rtl/sync_fifo_param.sv
// sync_fifo_param
// Single-clock parametrised FIFO for the UART TX/RX datapath.
// Storage is an unreset register array addressed by two wrapping pointers.
// An explicit occupancy counter drives all status flags. Every flag is
// registered from the next-count value, so it changes on the same edge as
// count.
//
// Parameters:
//   word_width : data word width in bits
//   addr_size  : depth = 2**addr_size words
//   af_level   : almost_full when count >= af_level (1..depth)
//   ae_level   : almost_empty when count <= ae_level (0..depth-1)
//   fwft       : 0 = registered read data, 1 = first-word-fall-through
//
// Ports:
//   clk          : clock; all state changes on the rising edge
//   reset_n      : asynchronous active-low reset
//   wr / rd      : write request / read request (read acknowledge in FWFT mode)
//   clr_err      : synchronous clear of overflow/underflow
//   data_in      : write data
//   data_out     : read data
//   full / empty : count == depth / count == 0
//   almost_full  : count >= af_level
//   almost_empty : count <= ae_level
//   count        : stored words, 0..depth
//   overflow     : sticky; set by a write while full
//   underflow    : sticky; set by a read while empty
module sync_fifo_param #(
  parameter int word_width = 8,
  parameter int addr_size  = 4,
  parameter int af_level   = (1 << addr_size) - 2,
  parameter int ae_level   = 2,
  parameter bit fwft       = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  wr,
  input  logic                  rd,
  input  logic                  clr_err,
  input  logic [word_width-1:0] data_in,
  output logic [word_width-1:0] data_out,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [addr_size:0]    count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 1 << addr_size;
  localparam int CNT_W = addr_size + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(af_level);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(ae_level);

  logic [word_width-1:0] mem [DEPTH];

  logic [addr_size-1:0] wptr_q, wptr_d;
  logic [addr_size-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 full_q, full_d;
  logic                 empty_q, empty_d;
  logic                 af_q, af_d;
  logic                 ae_q, ae_d;
  logic                 ovf_q, ovf_d;
  logic                 udf_q, udf_d;
  logic                 wr_acc, rd_acc;

  always_comb begin
    // Acceptance is judged against the registered flags, so at full a
    // simultaneous read is taken and the write dropped (and vice versa at empty).
    wr_acc  = wr && !full_q;
    rd_acc  = rd && !empty_q;
    wptr_d  = wr_acc ? wptr_q + addr_size'(1) : wptr_q;
    rptr_d  = rd_acc ? rptr_q + addr_size'(1) : rptr_q;
    count_d = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    full_d  = (count_d == DEPTH_C);
    empty_d = (count_d == '0);
    af_d    = (count_d >= AF_C);
    ae_d    = (count_d <= AE_C);
    // A set event in the same cycle as clr_err wins.
    ovf_d   = (wr && full_q)  || (ovf_q && !clr_err);
    udf_d   = (rd && empty_q) || (udf_q && !clr_err);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      af_q    <= af_d;
      ae_q    <= ae_d;
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
    end
  end

  // Storage has no reset; stale words are unreachable once the pointers reset.
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wptr_q] <= data_in;
  end

  generate
    if (fwft) begin : g_fwft
      // Head word presented combinationally; forced to zero while empty so the
      // output never shows stale or uninitialised storage.
      assign data_out = empty_q ? '0 : mem[rptr_q];
    end else begin : g_std
      logic [word_width-1:0] dout_q, dout_d;

      always_comb begin
        dout_d = rd_acc ? mem[rptr_q] : dout_q;
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) dout_q <= '0;
        else          dout_q <= dout_d;
      end

      assign data_out = dout_q;
    end
  endgenerate

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// Testbench for sync_fifo_param: one standard-mode instance driven by a
// vector table plus hand-written sequences, and one FWFT instance.
module tb_sync_fifo_param;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       wr, rd, clr_err;
  logic [7:0] din, dout;
  logic       full, empty, af, ae, ovf, udf;
  logic [4:0] cnt;

  logic       f_wr, f_rd, f_clr;
  logic [7:0] f_din, f_dout;
  logic       f_full, f_empty, f_af, f_ae, f_ovf, f_udf;
  logic [4:0] f_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] q[$];

  always #5 clk = ~clk;

  sync_fifo_param #(.word_width(8), .addr_size(4), .fwft(1'b0)) u_std (
    .clk(clk), .reset_n(reset_n), .wr(wr), .rd(rd), .clr_err(clr_err),
    .data_in(din), .data_out(dout), .full(full), .empty(empty),
    .almost_full(af), .almost_empty(ae), .count(cnt),
    .overflow(ovf), .underflow(udf)
  );

  sync_fifo_param #(.word_width(8), .addr_size(4), .fwft(1'b1)) u_fwft (
    .clk(clk), .reset_n(reset_n), .wr(f_wr), .rd(f_rd), .clr_err(f_clr),
    .data_in(f_din), .data_out(f_dout), .full(f_full), .empty(f_empty),
    .almost_full(f_af), .almost_empty(f_ae), .count(f_cnt),
    .overflow(f_ovf), .underflow(f_udf)
  );

  typedef struct {
    logic       wr;
    logic       rd;
    logic       clr;
    logic [7:0] din;
    logic [4:0] cnt;
    logic [5:0] flags;   // {full, empty, almost_full, almost_empty, overflow, underflow}
    logic [7:0] dout;
  } vec_t;

  vec_t vecs[36];

  function automatic logic [5:0] fl(input int c, input bit o, input bit u);
    return {c == 16, c == 0, c >= 14, c <= 2, o, u};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One standard-instance cycle with the queue model tracking expected data.
  task automatic cyc(input bit w, input bit r, input bit c, input logic [7:0] d);
    bit         w_ok, r_ok;
    logic [7:0] exp_d;
    @(negedge clk);
    wr = w; rd = r; clr_err = c; din = d;
    w_ok  = w && (q.size() < 16);
    r_ok  = r && (q.size() > 0);
    exp_d = 8'h00;
    if (r_ok) exp_d = q.pop_front();
    if (w_ok) q.push_back(d);
    @(posedge clk);
    #1;
    check("seq count", 32'(cnt), 32'(q.size()));
    if (r_ok) check("seq data", 32'(dout), 32'(exp_d));
  endtask

  task automatic fcyc(input bit w, input bit r, input logic [7:0] d);
    @(negedge clk);
    f_wr = w; f_rd = r; f_din = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    wr = 0; rd = 0; clr_err = 0; din = 0;
    f_wr = 0; f_rd = 0; f_clr = 0; f_din = 0;

    for (int i = 0; i < 16; i++)
      vecs[i] = '{1'b1, 1'b0, 1'b0, 8'(i), 5'(i + 1), fl(i + 1, 0, 0), 8'h00};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 8'hAA, 5'd16, fl(16, 1, 0), 8'h00};
    vecs[17] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd16, fl(16, 0, 0), 8'h00};
    for (int k = 0; k < 16; k++)
      vecs[18 + k] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'(15 - k), fl(15 - k, 0, 0), 8'(k)};
    vecs[34] = '{1'b0, 1'b1, 1'b0, 8'h00, 5'd0, fl(0, 0, 1), 8'h0F};
    vecs[35] = '{1'b0, 1'b0, 1'b1, 8'h00, 5'd0, fl(0, 0, 0), 8'h0F};

    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check("reset count", 32'(cnt), 0);
    check("reset flags", 32'({full, empty, af, ae, ovf, udf}), 32'(6'b010100));
    check("reset dout", 32'(dout), 0);
    check("reset fwft count", 32'(f_cnt), 0);
    check("reset fwft flags", 32'({f_full, f_empty, f_af, f_ae, f_ovf, f_udf}), 32'(6'b010100));

    // Fill, overflow, clear, drain, underflow, clear.
    for (int i = 0; i < 36; i++) begin
      @(negedge clk);
      wr = vecs[i].wr; rd = vecs[i].rd; clr_err = vecs[i].clr; din = vecs[i].din;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d count", i), 32'(cnt), 32'(vecs[i].cnt));
      check($sformatf("vec%0d flags", i), 32'({full, empty, af, ae, ovf, udf}), 32'(vecs[i].flags));
      check($sformatf("vec%0d dout", i), 32'(dout), 32'(vecs[i].dout));
    end
    cyc(0, 0, 0, 8'h00);

    // Simultaneous access at count 5.
    for (int i = 0; i < 5; i++) cyc(1, 0, 0, 8'(8'h50 + i));
    cyc(1, 1, 0, 8'h55);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 8'h00);

    // 40 words through the FIFO, pointers wrap several times.
    for (int i = 0; i < 10; i++) cyc(1, 0, 0, 8'(8'h80 + i));
    for (int i = 0; i < 30; i++) cyc(1, 1, 0, 8'(8'h8A + i));
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 8'h00);

    // Simultaneous access at full.
    for (int i = 0; i < 16; i++) cyc(1, 0, 0, 8'(8'hC0 + i));
    check("full before sim", 32'(full), 1);
    cyc(1, 1, 0, 8'hEE);
    check("full sim ovf", 32'(ovf), 1);
    check("full sim full", 32'(full), 0);
    cyc(0, 0, 1, 8'h00);
    check("ovf cleared", 32'(ovf), 0);
    for (int i = 0; i < 15; i++) cyc(0, 1, 0, 8'h00);

    // Simultaneous access at empty.
    cyc(1, 1, 0, 8'h77);
    check("empty sim udf", 32'(udf), 1);
    check("empty sim empty", 32'(empty), 0);
    cyc(0, 1, 0, 8'h00);

    // Standard-mode read latency and hold.
    cyc(1, 0, 0, 8'h11);
    cyc(1, 0, 0, 8'h22);
    check("dout hold before rd", 32'(dout), 32'(8'h77));
    cyc(0, 1, 0, 8'h00);
    check("std latency", 32'(dout), 32'(8'h11));
    cyc(0, 0, 0, 8'h00);
    cyc(0, 0, 0, 8'h00);
    check("std hold", 32'(dout), 32'(8'h11));

    // Async reset at count 7 with underflow still set.
    for (int i = 0; i < 6; i++) cyc(1, 0, 0, 8'(8'hD0 + i));
    check("pre-reset count", 32'(cnt), 7);
    check("pre-reset udf", 32'(udf), 1);
    @(negedge clk);
    wr = 0; rd = 0; clr_err = 0;
    #2 reset_n = 1'b0;
    #1;
    check("async count", 32'(cnt), 0);
    check("async flags", 32'({full, empty, af, ae, ovf, udf}), 32'(6'b010100));
    check("async dout", 32'(dout), 0);
    q.delete();
    #1 reset_n = 1'b1;

    // FWFT instance.
    fcyc(1, 0, 8'h3C);
    check("fwft empty after wr", 32'(f_empty), 0);
    check("fwft head", 32'(f_dout), 32'(8'h3C));
    check("fwft count 1", 32'(f_cnt), 1);
    fcyc(0, 1, 8'h00);
    check("fwft empty after rd", 32'(f_empty), 1);
    check("fwft count 0", 32'(f_cnt), 0);
    fcyc(1, 0, 8'hA1);
    check("fwft head A1", 32'(f_dout), 32'(8'hA1));
    fcyc(1, 0, 8'hB2);
    check("fwft head held", 32'(f_dout), 32'(8'hA1));
    check("fwft count 2", 32'(f_cnt), 2);
    fcyc(0, 1, 8'h00);
    check("fwft next head", 32'(f_dout), 32'(8'hB2));
    fcyc(0, 1, 8'h00);
    check("fwft drained", 32'(f_empty), 1);
    fcyc(0, 0, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_fifo_param.md
# sync_fifo_param

Single-clock, parametrised FIFO for the UART datapath, where TX and RX buffering sit in one clock domain. It is the successor to the dual-clock FIFO: it keeps the `wr`/`rd`/`full`/`empty` contract and adds configurable depth, an occupancy count, programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and a first-word-fall-through (FWFT) read mode. Storage is an internal register array with no reset.

## Interface
- `word_width`, default 8: data word width in bits.
- `addr_size`, default 4: depth = 2^addr_size words.
- `af_level`, default 2^addr_size-2: `almost_full` asserts when count >= af_level; legal range is 1..depth.
- `ae_level`, default 2: `almost_empty` asserts when count <= ae_level; legal range is 0..depth-1.
- `fwft`, default 0: 0 selects standard registered read, 1 selects first-word-fall-through.
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `wr` in 1: write request.
- `rd` in 1: read request.
- `clr_err` in 1: synchronous clear of the sticky error flags.
- `data_in` in word_width: write data.
- `data_out` out word_width: read data.
- `full` out 1: count == depth.
- `empty` out 1: count == 0.
- `almost_full` out 1: count >= af_level.
- `almost_empty` out 1: count <= ae_level.
- `count` out addr_size+1: number of stored words, 0..depth.
- `overflow` out 1: sticky; set by a write attempted while full.
- `underflow` out 1: sticky; set by a read attempted while empty.

## Operation
- A write is accepted when `wr && !full`. `data_in` goes to mem[wptr], then wptr increments.
- A read is accepted when `rd && !empty`, then rptr increments.
- Both pointers are addr_size bits and wrap naturally from depth-1 to 0.
- Count update per cycle:
  - write accepted only: +1.
  - read accepted only: -1.
  - both accepted, or neither: unchanged.
- Simultaneous `wr` and `rd`:
  - Full: the read is accepted, the write is rejected, `overflow` sets, count becomes depth-1.
  - Empty: the write is accepted, the read is rejected, `underflow` sets, count becomes 1.
  - Otherwise: both are accepted and count is unchanged.
- All status flags are registered and derived from the next count value, so they are correct in the same cycle as `count`.
- `overflow` and `underflow` stay set until `clr_err` or reset. If a set event and `clr_err` occur in the same cycle, the set event wins.
- Standard mode (`fwft`=0):
  - `data_out` is a register loaded with mem[rptr] on an accepted read.
  - It holds its value at all other times, including after empty.
- FWFT mode (`fwft`=1):
  - `data_out` = mem[rptr] combinationally, so the head word is presented whenever `!empty`.
  - `rd` acts as an acknowledge that pops the head.
  - `data_out` is don't-care while `empty`.
- Rejected operations do not change pointers, count or memory.

## Timing
- Reset values: wptr=0, rptr=0, count=0, `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `overflow`=0, `underflow`=0, `data_out`=0.
- Reset acts immediately on `reset_n` low. Reset mid-operation discards all contents; memory contents are undefined but unreachable.
- Write to flag: a write at edge N gives count+1 and updated flags visible after edge N.
- FWFT first word: the written word is on `data_out` in the cycle after the write edge, when `empty` falls.
- Standard read latency: 1 cycle; `data_out` is valid after the edge that accepts `rd`.
- FWFT read: the next word appears after the edge that accepts `rd`.
- Sustained throughput: one write and one read per cycle.

## Test plan
- Reset, then fill: addr_size=4, write 0x00..0x0F on consecutive cycles.
  - `full` rises after the 16th edge and count=16.
  - `almost_full` rises when count reaches 14.
  - `empty` and `almost_empty` clear at count 1 and count 3 respectively.
- Overflow: with the FIFO full, pulse `wr` with data 0xAA.
  - count stays 16 and `overflow`=1.
  - Draining returns 0x00..0x0F; 0xAA never appears.
  - `clr_err` clears `overflow`.
- Underflow and wrap-around: drain to empty, pulse `rd` → `underflow`=1 and count stays 0. Then write and read 40 words → output order is preserved across pointer wrap.
- Simultaneous access:
  - At count=5, `wr`+`rd` → count stays 5, data stays ordered.
  - At full, `wr`+`rd` → count=15, `overflow`=1.
  - At empty, `wr`+`rd` → count=1, `underflow`=1.
- FWFT: with `fwft`=1, write 0x3C at edge N.
  - `empty`=0 and `data_out`=0x3C after edge N.
  - `rd` at the next edge → `empty`=1 and count=0.
- Standard-mode latency: write 0x11 and 0x22, then assert `rd`.
  - `data_out`=0x11 exactly one edge after the `rd` edge.
  - `data_out` holds 0x11 while `rd`=0.
- Async reset mid-stream: at count=7, pulse `reset_n` low between edges → all outputs return to their reset values immediately.
